parity_serial_receiver: RTL and testbench

//  Serial receiver with parity check: deserialises one framed byte from a

---
 rtl/parity_serial_receiver.sv | 189 ++++++++++++++++++
 tb/tb_parity_serial_receiver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/parity_serial_receiver.sv
// ---------------------------------------------------------------------------
// parity_serial_receiver
//   Deserialises one framed word from a single-wire line, checks its parity
//   and presents the word in parallel with status flags.
//   Frame: idle high, start(0), DATA_BITS data bits LSB first, parity, stop(1).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//   DATA_BITS     data bits per frame (1..8)
//   PARITY_ODD    0: data+parity has an even number of ones, 1: odd
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   rx          serial line, asynchronous to clock
//   data_out    last received word, LSB = first data bit
//   rx_done     one-cycle pulse: frame complete, data_out/flags updated
//   parity_err  parity mismatch on last frame
//   frame_err   stop bit sampled low on last frame
//   busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module parity_serial_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                 rx_meta, rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 pbit_q;

  logic                 mid_hit, end_hit;
  logic                 sample;     // any sampling point this cycle
  logic                 shift_en;   // capture a data bit
  logic                 pbit_en;    // capture the parity bit
  logic                 stop_en;    // capture the stop bit and publish

  // shift right, newest bit enters at the MSB; the extra bit keeps the
  // slice legal when DATA_BITS == 1
  logic [DATA_BITS:0]   shift_ext;

  assign mid_hit   = (cnt == HALF_M1);
  assign end_hit   = (cnt == FULL_M1);
  assign shift_ext = {rx_s, shift_q};

  // -------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      // mid-bit recheck rejects glitches shorter than half a bit
      START:     if (mid_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (end_hit && (bit_idx == LAST_IDX)) state_nxt = PARITY;
      PARITY:    if (end_hit) state_nxt = STOP;
      // a line still low after the stop bit must return high before a new
      // start can be recognised
      STOP:      if (end_hit) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs / strobes
  // -------------------------------------------------------------------------
  always_comb begin
    busy     = (state != IDLE);
    shift_en = 1'b0;
    pbit_en  = 1'b0;
    stop_en  = 1'b0;
    sample   = 1'b0;
    case (state)
      START:  sample = mid_hit;
      DATA:   begin sample = end_hit; shift_en = end_hit; end
      PARITY: begin sample = end_hit; pbit_en  = end_hit; end
      STOP:   begin sample = end_hit; stop_en  = end_hit; end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bit-period counter: restarts on every state change and after each sample
  // so every bit period is measured from the previous sampling point.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state_nxt != state) || sample) begin
      cnt <= '0;
    end else if ((state == START) || (state == DATA) ||
                 (state == PARITY) || (state == STOP)) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_idx <= '0;
      shift_q <= '0;
      pbit_q  <= 1'b0;
    end else begin
      if (state == START) bit_idx <= '0;
      if (shift_en) begin
        shift_q <= shift_ext[DATA_BITS:1];
        bit_idx <= bit_idx + IW'(1);
      end
      if (pbit_en) pbit_q <= rx_s;
    end
  end

  // -------------------------------------------------------------------------
  // Published results: only change on the rx_done edge, then hold.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= stop_en;
      if (stop_en) begin
        data_out   <= shift_q;
        parity_err <= ((^shift_q) ^ pbit_q) != ODD;
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_parity_serial_receiver.sv
module tb_parity_serial_receiver;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx, rx2;
  logic [7:0] data_out, data_out2;
  logic       rx_done, parity_err, frame_err, busy;
  logic       rx_done2, parity_err2, frame_err2, busy2;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int done_cnt = 0, done_cnt2 = 0;
  int t_start = 0, last_lat = 0;
  logic [7:0] dlog[$];

  always #5 clock = ~clock;

  parity_serial_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .data_out(data_out), .rx_done(rx_done), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  parity_serial_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(1)) dut_odd (
    .clock(clock), .reset(reset), .rx(rx2),
    .data_out(data_out2), .rx_done(rx_done2), .parity_err(parity_err2),
    .frame_err(frame_err2), .busy(busy2)
  );

  always @(posedge clock) cyc = cyc + 1;

  // every high cycle counts, so a stretched rx_done shows up as extra pulses
  always @(negedge clock) begin
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      last_lat = cyc - t_start;
      dlog.push_back(data_out);
    end
    if (rx_done2) done_cnt2 = done_cnt2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // callers are positioned 1ns after a rising edge
  task automatic send_bit(input bit sel, input logic b);
    if (sel) rx2 = b; else rx = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic p, input logic s);
    t_start = cyc;
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    send_bit(sel, p);
    send_bit(sel, s);
  endtask

  task automatic idle(input int n);
    rx = 1'b1; rx2 = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int d0;
    logic [7:0] v;
    rx = 1'b1; rx2 = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_flags", {rx_done, parity_err, frame_err, busy}, 4'b0000);
    reset = 1'b0;
    idle(5);

    // 0xA5 (four ones), parity 0: clean even-parity frame
    d0 = done_cnt;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    idle(4);
    chk("a5_done", done_cnt - d0, 1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_perr", parity_err, 0);
    chk("a5_ferr", frame_err, 0);
    chk("a5_busy", busy, 0);
    chk("a5_lat_ok", (last_lat >= 169 && last_lat <= 172), 1);

    // 0xA5 with wrong parity bit
    d0 = done_cnt;
    send_frame(0, 8'hA5, 1'b1, 1'b1);
    idle(4);
    chk("a5p1_done", done_cnt - d0, 1);
    chk("a5p1_data", data_out, 8'hA5);
    chk("a5p1_perr", parity_err, 1);
    chk("a5p1_ferr", frame_err, 0);

    // 4-cycle glitch: START entered then rejected at the mid-bit recheck
    d0 = done_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("glitch_busy_hi", busy, 1);
    idle(20);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_data", data_out, 8'hA5);
    chk("glitch_perr", parity_err, 1);

    // 0x3C, stop bit 0, line held low
    d0 = done_cnt;
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("ferr_done", done_cnt - d0, 1);
    chk("ferr_flag", frame_err, 1);
    chk("ferr_data", data_out, 8'h3C);
    chk("ferr_perr", parity_err, 0);
    chk("ferr_wait_busy", busy, 1);
    idle(20);
    chk("ferr_release_busy", busy, 0);
    chk("ferr_no_more_done", done_cnt - d0, 1);

    // reset in the middle of the 4th data bit of a frame
    d0 = done_cnt;
    v = 8'h3C;
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, v[i]);
    rx = v[3];
    repeat (8) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mrst_data", data_out, 8'h00);
    chk("mrst_flags", {rx_done, parity_err, frame_err, busy}, 4'b0000);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(30);
    chk("mrst_no_done", done_cnt - d0, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    idle(4);
    chk("mrst_next_done", done_cnt - d0, 1);
    chk("mrst_next_data", data_out, 8'h3C);
    chk("mrst_next_flags", {parity_err, frame_err}, 2'b00);

    // back-to-back frames, no idle gap
    d0 = done_cnt;
    dlog.delete();
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    idle(4);
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_first", (dlog.size() > 0) ? dlog[0] : 8'hxx, 8'h00);
    chk("b2b_second", (dlog.size() > 1) ? dlog[1] : 8'hxx, 8'hFF);
    chk("b2b_flags", {parity_err, frame_err}, 2'b00);

    // odd-parity instance: 0x01 has one 1
    d0 = done_cnt2;
    send_frame(1, 8'h01, 1'b0, 1'b1);
    idle(4);
    chk("odd_p0_done", done_cnt2 - d0, 1);
    chk("odd_p0_data", data_out2, 8'h01);
    chk("odd_p0_perr", parity_err2, 0);
    send_frame(1, 8'h01, 1'b1, 1'b1);
    idle(4);
    chk("odd_p1_done", done_cnt2 - d0, 2);
    chk("odd_p1_perr", parity_err2, 1);
    chk("odd_p1_ferr", frame_err2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // watchdog: the directed sequence is a few thousand cycles
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
